// File: rtl/lsu_dbus_master_pkg.sv
// Shared encodings and store-steering helpers for the load/store bus master.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    // Size 2'b11 falls into the word case on purpose.
    function automatic logic [3:0] lsu_wmask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: lsu_wmask = 4'b0001 << a;
            SZ_HALF: lsu_wmask = a[1] ? 4'b1100 : 4'b0011;
            default: lsu_wmask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: lsu_wdata = {4{d[7:0]}};
            SZ_HALF: lsu_wdata = {2{d[15:0]}};
            default: lsu_wdata = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dbus_master_if.sv
// Word-addressed data bus with a valid/ack handshake.
interface lsu_dbus_master_if #(
    parameter int ADDR_W = 32
);
    logic              dbus_req_out;
    logic              dbus_wr_out;
    logic [ADDR_W-1:0] dbus_addr_out;
    logic [31:0]       dbus_wdata_out;
    logic [3:0]        dbus_wmask_out;
    logic              dbus_ack_in;
    logic              dbus_err_in;
    logic [31:0]       dbus_rdata_in;

    modport master (
        output dbus_req_out, dbus_wr_out, dbus_addr_out, dbus_wdata_out, dbus_wmask_out,
        input  dbus_ack_in, dbus_err_in, dbus_rdata_in
    );

    modport slave (
        input  dbus_req_out, dbus_wr_out, dbus_addr_out, dbus_wdata_out, dbus_wmask_out,
        output dbus_ack_in, dbus_err_in, dbus_rdata_in
    );
endinterface

// File: rtl/lsu_dbus_master_load_aligner.sv
// Picks the addressed byte/half lane out of a bus word and extends it to 32 bits.
module lsu_load_aligner
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_dbus_master.sv
// Load/store unit: one outstanding bus access at a time, stalling the core while busy.
module lsu_dbus_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              load_req_in,
    input  logic              store_req_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       store_data_in,
    input  logic [1:0]        size_in,
    input  logic              unsigned_in,
    output logic              stall_out,
    output logic [31:0]       load_data_out,
    output logic              load_valid_out,
    output logic              store_done_out,
    output logic              access_fault_out,
    lsu_dbus_master_if.master dbus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        r_state, w_next;
    logic              w_capture, w_done, w_timeout;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_store, r_unsigned, r_fault;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_rdata, w_aligned;
    logic [3:0]        r_wmask;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Ack wins over a timeout landing in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (store_req_in || load_req_in) begin
                    w_next    = ST_BUSY;
                    w_capture = 1'b1;
                end
            end
            ST_BUSY: begin
                if (dbus.dbus_ack_in) begin
                    w_next = ST_RESP;
                    w_done = 1'b1;
                end else if (r_cnt == CNT_MAX) begin
                    w_next    = ST_RESP;
                    w_timeout = 1'b1;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_is_store <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_rdata    <= '0;
            r_fault    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_capture) begin
                // Store has priority when both requests arrive together.
                r_is_store <= store_req_in;
                r_unsigned <= unsigned_in;
                r_size     <= size_in;
                r_addr     <= addr_in;
                r_wdata    <= lsu_wdata(size_in, store_data_in);
                r_wmask    <= store_req_in ? lsu_wmask(size_in, addr_in[1:0]) : 4'b0000;
            end
            if (w_done) begin
                r_rdata <= dbus.dbus_rdata_in;
                r_fault <= dbus.dbus_err_in;
            end else if (w_timeout) begin
                r_fault <= 1'b1;
            end
            if (r_state == ST_BUSY && !w_done && !w_timeout) r_cnt <= r_cnt + 1'b1;
            else                                             r_cnt <= '0;
        end
    end

    lsu_load_aligner u_align (
        .i_rdata    (r_rdata),
        .i_addr_lo  (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_aligned)
    );

    // Request is decoded straight from state so reset drops it without waiting for a clock.
    assign dbus.dbus_req_out   = (r_state == ST_BUSY);
    assign dbus.dbus_wr_out    = r_is_store;
    assign dbus.dbus_addr_out  = {r_addr[ADDR_W-1:2], 2'b00};
    assign dbus.dbus_wdata_out = r_wdata;
    assign dbus.dbus_wmask_out = r_wmask;

    assign stall_out        = ((r_state == ST_IDLE) && (load_req_in || store_req_in)) ||
                              (r_state == ST_BUSY);
    assign load_valid_out   = (r_state == ST_RESP) && !r_is_store && !r_fault;
    assign store_done_out   = (r_state == ST_RESP) &&  r_is_store && !r_fault;
    assign access_fault_out = (r_state == ST_RESP) &&  r_fault;
    assign load_data_out    = r_fault ? 32'h0 : w_aligned;

endmodule

// File: doc/lsu_dbus_master.md
Name: lsu_dbus_master

Overview:
- Load/store unit sitting downstream of the instruction decoder. It is the memory-side consumer of the decoder's load/store controls.
- Accepts one load or store request from the execute stage and drives a word-addressed data bus with a valid/ack handshake.
- Generates byte-lane write data and masks for stores. Aligns and sign/zero-extends returned load data.
- Stalls the core pipeline while a transaction is outstanding. Reports bus errors and timeouts as an access fault.

Parameters:
- TIMEOUT_CYCLES, 255: number of BUSY cycles without ack before a timeout fault. Minimum 1.
- ADDR_W, 32: byte-address width.

Ports:
- clk_in  input  1  core clock; all state changes on the rising edge.
- rst_in  input  1  asynchronous active-high reset.
- load_req_in  input  1  load request, already qualified by the core as non-misaligned.
- store_req_in  input  1  store request (the decoder's memory write request).
- addr_in  input  ADDR_W  byte address from the immediate adder.
- store_data_in  input  32  rs2 value.
- size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- unsigned_in  input  1  1 = zero-extend load, 0 = sign-extend.
- stall_out  output  1  hold the pipeline.
- load_data_out  output  32  extended load result.
- load_valid_out  output  1  one-cycle pulse; load_data_out is valid.
- store_done_out  output  1  one-cycle pulse on store completion.
- access_fault_out  output  1  one-cycle pulse; bus error or timeout.
- dbus_req_out  output  1  bus request valid.
- dbus_wr_out  output  1  1 = write.
- dbus_addr_out  output  ADDR_W  word-aligned address, low 2 bits forced to 0.
- dbus_wdata_out  output  32  lane-replicated write data.
- dbus_wmask_out  output  4  byte enables; 0000 for reads.
- dbus_ack_in  input  1  responder accepts/completes the request this cycle.
- dbus_err_in  input  1  sampled only when dbus_ack_in=1.
- dbus_rdata_in  input  32  read data, valid when dbus_ack_in=1.

Behaviour:
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE. All registered outputs reset to 0; the timeout counter resets to 0.
- IDLE:
  - If store_req_in or load_req_in, capture addr/data/size/unsigned/type into registers and go to BUSY.
  - If both requests are high, the store is taken and the load is ignored.
- BUSY:
  - dbus_req_out=1. Address, wdata, wmask and wr are driven from registers and held stable until ack.
  - On dbus_ack_in, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack, go to RESP with a fault flag set. The counter clears on leaving BUSY.
- RESP (exactly 1 cycle):
  - dbus_req_out=0.
  - Pulse load_valid_out (load, no fault), store_done_out (store, no fault), or access_fault_out (err or timeout).
  - Return to IDLE.
- stall_out (combinational) = (IDLE & (load_req_in | store_req_in)) | BUSY. It is low in RESP, so the pipeline advances in the pulse cycle.
- Latency: request in cycle N; dbus_req_out high from N+1; ack at earliest N+1; result pulse at N+2. Minimum 2-cycle access, back-to-back requests allowed from RESP+1 (the cycle after RESP).
- Store steering:
  - byte: wdata={4{d[7:0]}}, mask=0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, mask=addr[1]?1100:0011; addr[0] ignored.
  - word: wdata=d, mask=1111.
- Load extraction:
  - byte: lane addr[1:0]. half: lane addr[1]. word: full 32 bits.
  - Extend to 32 bits per unsigned_in.
  - Read data is registered at ack and presented in RESP.
- On fault, load_data_out=0.
- Ack seen in IDLE or RESP is ignored.
- Reset mid-transaction: FSM returns to IDLE and dbus_req_out drops asynchronously. A late ack after reset is ignored.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state encoding (2-bit IDLE/BUSY/RESP).
  - Default timeout constant.
- One combinational sub-module lsu_load_aligner: rdata, addr[1:0], size, unsigned -> 32-bit extended result. Reused by the verification model.

Test Plan:
- Store byte, addr=0x1003, data=0xA5, ack at first request cycle -> dbus_addr_out=0x1000, wdata=0xA5A5A5A5, mask=1000; store_done_out pulse at N+2; stall_out high N..N+1.
- Load half signed, addr=0x2002, rdata=0x8001_1234, ack delayed 3 cycles -> load_data_out=0xFFFF8001, load_valid_out 1 cycle; req held with stable addr 0x2000.
- Load byte unsigned, addr=0x3001, rdata=0x0000_F000 -> load_data_out=0x000000F0.
- Load word with dbus_err_in=1 at ack -> access_fault_out pulse, load_valid_out=0, load_data_out=0.
- TIMEOUT_CYCLES=4, no ack -> req high exactly 4 cycles, access_fault_out pulse next cycle, back to IDLE.
- Assert rst_in during BUSY, then ack after reset -> dbus_req_out=0 immediately, no pulse outputs; a following store completes normally.
